instr_fetch_queue: RTL and testbench
====================================

Name: instr_fetch_queue

Overview:
Parametrised successor to the single-register instruction fetch stage of the 5-stage MIPS-lite pipeline. Owns the PC and issues in-order requests to a variable-latency instruction memory. Buffers returned words in a prefetch queue and presents PC/instruction pairs to decode with a valid/ready handshake. Supports branch/jump redirect with flush and discard of in-flight stale responses.

Parameters:
ADDRESSWIDTH, 32, PC and memory address width in bits
DATAWIDTH, 32, instruction word width in bits
QDEPTH, 4, prefetch queue entries; power of two, >= 2
RESET_PC, 0, PC value loaded on reset
PC_STEP, 4, PC increment per sequential fetch

Ports:
clk  in  1  clock; all flops on rising edge
reset  in  1  asynchronous, active-low reset
imem_req_valid  out  1  fetch request valid
imem_req_addr  out  ADDRESSWIDTH  fetch address
imem_req_ready  in  1  memory accepts request this cycle
imem_rsp_valid  in  1  response word valid; responses return in request order, always accepted
imem_rsp_data  in  DATAWIDTH  response instruction word
redirect_valid  in  1  branch/jump taken from EX; flush and refetch
redirect_pc  in  ADDRESSWIDTH  redirect target
if_valid  out  1  instruction available to decode
if_instr  out  DATAWIDTH  instruction at queue head
if_pc  out  ADDRESSWIDTH  PC of if_instr
id_ready  in  1  decode consumes head this cycle when if_valid=1
halted  out  1  fetch stopped on halt opcode (see Optional Feature)

Behaviour:
- Reset (reset=0, async): fetch_pc=RESET_PC, queue empty, outstanding=0, drop=0, halted=0; imem_req_valid=0, if_valid=0, if_instr=0, if_pc=0. First request may assert the cycle after reset deasserts.
- Request issue: imem_req_valid=1 iff (occupancy + outstanding) < QDEPTH and not halted and not redirect_valid. imem_req_addr=fetch_pc. On valid&&ready: fetch_pc += PC_STEP (modulo 2^ADDRESSWIDTH, wraps silently), outstanding++. The address is held stable while valid&&!ready.
- Each issued request pushes its PC into a pending-PC FIFO (depth QDEPTH). On rsp_valid: pop pending PC and outstanding--. If drop>0, discard the word and decrement drop. Otherwise enqueue {pc, data}.
- Credit rule guarantees no queue overflow. A response arriving with occupancy==QDEPTH is a protocol error; an SVA assertion fires.
- Output: if_valid = occupancy>0. if_instr/if_pc come from the head combinationally. Head is popped on if_valid&&id_ready. Enqueue and dequeue in the same cycle at full or empty is legal; occupancy is unchanged.
- Latency: request accepted at cycle N, response at cycle M -> if_valid at M+1 (registered queue write). No bypass.
- Redirect (priority over all else, same cycle):
  - queue cleared; fetch_pc=redirect_pc; halted=0.
  - drop = outstanding minus any response consumed this cycle.
  - No request issues in the redirect cycle.
  - if_valid falls the next cycle.
  - A response in the redirect cycle is discarded.
- Redirect while drop>0: drop accumulates correctly (total stale in flight). Counters are sized clog2(QDEPTH)+1.

Optional Feature:
HALT_DETECT_EN: when defined, a word with instr[31:26]==6'b010001 (MIPS-lite HALT) being enqueued sets halted=1. That word is still enqueued and delivered. Later non-dropped responses are discarded, and no new requests issue until redirect or reset. When undefined, halted is tied 0 and HALT is treated as an ordinary instruction.

Test Plan:
- Reset then id_ready=1, zero-latency memory returning addr as data -> if_pc/if_instr sequence 0,4,8,12..., one per cycle after fill.
- id_ready=0 for 10 cycles, memory ready -> exactly QDEPTH=4 requests issue, imem_req_valid drops, if_pc held at 0. On release, a 0,4,8,12 burst delivers with no gaps or duplicates.
- Memory latency 3, redirect_pc=0x100 with 2 responses in flight -> both stale words dropped, next if_pc=0x100.
- imem_req_ready=0 for 5 cycles -> imem_req_addr stable, no PC advance; outstanding unchanged.
- Assert reset mid-burst with 3 queued -> if_valid=0 immediately (async). After release, fetch restarts at RESET_PC.
- HALT_DETECT_EN with HALT at 0x8 -> instrs at 0,4,8 delivered, halted=1, no further requests. Redirect to 0x20 -> halted=0, fetch resumes at 0x20.

Source files
------------

// File: rtl/instr_fetch_queue.sv
// Instruction fetch stage with a prefetch queue and in-order variable-latency memory interface.
// Define HALT_DETECT_EN to stop fetching once a HALT opcode is enqueued.
module instr_fetch_queue #(
    parameter int ADDRESSWIDTH = 32,
    parameter int DATAWIDTH    = 32,
    parameter int QDEPTH       = 4,
    parameter logic [ADDRESSWIDTH-1:0] RESET_PC = '0,
    parameter int PC_STEP      = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    output logic                    imem_req_valid,
    output logic [ADDRESSWIDTH-1:0] imem_req_addr,
    input  logic                    imem_req_ready,
    input  logic                    imem_rsp_valid,
    input  logic [DATAWIDTH-1:0]    imem_rsp_data,
    input  logic                    redirect_valid,
    input  logic [ADDRESSWIDTH-1:0] redirect_pc,
    output logic                    if_valid,
    output logic [DATAWIDTH-1:0]    if_instr,
    output logic [ADDRESSWIDTH-1:0] if_pc,
    input  logic                    id_ready,
    output logic                    halted
);

    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;

    typedef logic [CW-1:0] cnt_t;
    typedef logic [PW-1:0] ptr_t;

    logic [ADDRESSWIDTH-1:0] fetch_pc_q, fetch_pc_d;
    ptr_t                    q_head_q, q_head_d;
    ptr_t                    q_tail_q, q_tail_d;
    cnt_t                    q_count_q, q_count_d;
    ptr_t                    pend_rd_q, pend_rd_d;
    ptr_t                    pend_wr_q, pend_wr_d;
    cnt_t                    outstanding_q, outstanding_d;
    cnt_t                    drop_q, drop_d;
    logic                    halted_q, halted_d;
    logic                    run_q;

    logic [ADDRESSWIDTH-1:0] q_pc_mem    [QDEPTH];
    logic [DATAWIDTH-1:0]    q_instr_mem [QDEPTH];
    logic [ADDRESSWIDTH-1:0] pend_pc_mem [QDEPTH];

    logic                    req_valid;
    logic                    req_fire;
    logic                    enq;
    logic                    deq;
    logic                    halt_hit;
    logic [CW:0]             credits;
    logic [ADDRESSWIDTH-1:0] rsp_pc;

`ifdef HALT_DETECT_EN
    assign halt_hit = (imem_rsp_data[31:26] == 6'b010001);
`else
    assign halt_hit = 1'b0;
`endif

    // Queue entries plus requests still in flight may never exceed the queue size.
    assign credits   = {1'b0, q_count_q} + {1'b0, outstanding_q};
    assign req_valid = run_q && (credits < (CW+1)'(QDEPTH)) && !halted_q && !redirect_valid;
    assign req_fire  = req_valid && imem_req_ready;
    assign deq       = if_valid && id_ready;
    assign rsp_pc    = pend_pc_mem[pend_rd_q];

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        q_head_d      = q_head_q;
        q_tail_d      = q_tail_q;
        q_count_d     = q_count_q;
        pend_rd_d     = pend_rd_q;
        pend_wr_d     = pend_wr_q;
        outstanding_d = outstanding_q;
        drop_d        = drop_q;
        halted_d      = halted_q;
        enq           = 1'b0;

        if (imem_rsp_valid) begin
            pend_rd_d = pend_rd_q + 1'b1;
        end

        if (redirect_valid) begin
            // Everything still in flight is stale, including words already marked for drop.
            fetch_pc_d    = redirect_pc;
            q_head_d      = '0;
            q_tail_d      = '0;
            q_count_d     = '0;
            halted_d      = 1'b0;
            outstanding_d = outstanding_q - cnt_t'(imem_rsp_valid);
            drop_d        = outstanding_q - cnt_t'(imem_rsp_valid);
        end else begin
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + ADDRESSWIDTH'(PC_STEP);
                pend_wr_d  = pend_wr_q + 1'b1;
            end
            outstanding_d = outstanding_q + cnt_t'(req_fire) - cnt_t'(imem_rsp_valid);

            if (imem_rsp_valid) begin
                if (drop_q != '0) begin
                    drop_d = drop_q - 1'b1;
                end else if (!halted_q) begin
                    enq = 1'b1;
                    if (halt_hit) begin
                        halted_d = 1'b1;
                    end
                end
            end

            if (enq) begin
                q_tail_d = q_tail_q + 1'b1;
            end
            if (deq) begin
                q_head_d = q_head_q + 1'b1;
            end
            q_count_d = q_count_q + cnt_t'(enq) - cnt_t'(deq);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc_q    <= RESET_PC;
            q_head_q      <= '0;
            q_tail_q      <= '0;
            q_count_q     <= '0;
            pend_rd_q     <= '0;
            pend_wr_q     <= '0;
            outstanding_q <= '0;
            drop_q        <= '0;
            halted_q      <= 1'b0;
            run_q         <= 1'b0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            q_head_q      <= q_head_d;
            q_tail_q      <= q_tail_d;
            q_count_q     <= q_count_d;
            pend_rd_q     <= pend_rd_d;
            pend_wr_q     <= pend_wr_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
            halted_q      <= halted_d;
            run_q         <= 1'b1;
        end
    end

    // Storage needs no reset: entries are only visible through the occupancy count.
    always_ff @(posedge clk) begin
        if (enq) begin
            q_pc_mem[q_tail_q]    <= rsp_pc;
            q_instr_mem[q_tail_q] <= imem_rsp_data;
        end
        if (req_fire) begin
            pend_pc_mem[pend_wr_q] <= fetch_pc_q;
        end
    end

    assign imem_req_valid = req_valid;
    assign imem_req_addr  = fetch_pc_q;
    assign if_valid       = (q_count_q != '0);
    assign if_instr       = if_valid ? q_instr_mem[q_head_q] : '0;
    assign if_pc          = if_valid ? q_pc_mem[q_head_q] : '0;
    assign halted         = halted_q;

    a_no_rsp_when_full: assert property (@(posedge clk) disable iff (!reset)
        !(imem_rsp_valid && (q_count_q == cnt_t'(QDEPTH))));

    a_no_rsp_without_req: assert property (@(posedge clk) disable iff (!reset)
        !(imem_rsp_valid && (outstanding_q == '0)));

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Randomized self-checking bench for instr_fetch_queue against a transaction-level fetch model.
module tb_instr_fetch_queue;

   localparam int QDEPTH = 4;
   localparam logic [31:0] RESET_PC = 32'h0;
`ifdef HALT_DETECT_EN
   localparam bit HALT_EN = 1'b1;
`else
   localparam bit HALT_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        imem_req_valid;
   logic [31:0] imem_req_addr;
   logic        imem_req_ready;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        if_valid;
   logic [31:0] if_instr;
   logic [31:0] if_pc;
   logic        id_ready;
   logic        halted;

   instr_fetch_queue #(
      .ADDRESSWIDTH(32),
      .DATAWIDTH(32),
      .QDEPTH(QDEPTH),
      .RESET_PC(RESET_PC),
      .PC_STEP(4)
   ) dut (
      .clk(clk),
      .reset(reset),
      .imem_req_valid(imem_req_valid),
      .imem_req_addr(imem_req_addr),
      .imem_req_ready(imem_req_ready),
      .imem_rsp_valid(imem_rsp_valid),
      .imem_rsp_data(imem_rsp_data),
      .redirect_valid(redirect_valid),
      .redirect_pc(redirect_pc),
      .if_valid(if_valid),
      .if_instr(if_instr),
      .if_pc(if_pc),
      .id_ready(id_ready),
      .halted(halted)
   );

   // Free-running clock, 10 time units per period
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      int          due;
   } memReq_t;

   // Memory model: accepted requests waiting to be answered, oldest first
   memReq_t memQ[$];
   int cycle;
   int lat;
   int lastDue;

   // Fetch model: what decode should see next, what memory should be asked next,
   // how many words are buffered, and how many in-flight words are stale
   logic [31:0] expPc;
   logic [31:0] expReqPc;
   int occ;
   int stale;
   bit mHalted;
   bit mRun;
   logic [31:0] haltAddr;

   int nReq;
   int nDel;
   int checks;
   int errors;

   // Instruction word the memory returns for an address; top opcode bits stay clear
   // for every address this bench uses except the chosen HALT address
   function automatic logic [31:0] memWord(input logic [31:0] a);
      if (a == haltAddr) return {6'b010001, 26'h0};
      return a ^ 32'h00C0_FFEE;
   endfunction

   // Single comparison point: counts every check and reports any mismatch
   task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, actual, expected, cycle);
      end
   endtask

   // Return the model to its just-reset state
   task automatic resetModel();
      memQ.delete();
      occ = 0;
      stale = 0;
      mHalted = 1'b0;
      mRun = 1'b0;
      expPc = RESET_PC;
      expReqPc = RESET_PC;
      lastDue = 0;
      nReq = 0;
      nDel = 0;
   endtask

   // Drive idle inputs, hold reset for two edges, release just after an edge
   task automatic doReset();
      reset = 1'b0;
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b0;
      imem_rsp_data = '0;
      redirect_valid = 1'b0;
      redirect_pc = '0;
      id_ready = 1'b0;
      resetModel();
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
   endtask

   // One clock cycle: drive inputs, compare outputs with the model at the negedge,
   // then advance the model by the transfers that happen at the coming edge
   task automatic applyStimulus(input bit rdy, input bit idr, input bit redir, input logic [31:0] rpc);
      memReq_t r;
      logic [31:0] w;
      int d;
      imem_req_ready = rdy;
      id_ready = idr;
      redirect_valid = redir;
      redirect_pc = rpc;
      if (memQ.size() > 0 && memQ[0].due <= cycle) begin
         imem_rsp_valid = 1'b1;
         imem_rsp_data = memWord(memQ[0].addr);
      end else begin
         imem_rsp_valid = 1'b0;
         imem_rsp_data = '0;
      end

      @(negedge clk);

      checkOutput("ifValid", if_valid, occ > 0);
      checkOutput("halted", halted, mHalted);
      if (mRun)
         checkOutput("reqValid", imem_req_valid, (occ + memQ.size() < QDEPTH) && !mHalted && !redir);
      if (imem_req_valid)
         checkOutput("reqAddr", imem_req_addr, expReqPc);

      if (!redir && occ > 0 && idr) begin
         checkOutput("ifPc", if_pc, expPc);
         checkOutput("ifInstr", if_instr, memWord(expPc));
         expPc += 4;
         occ--;
         nDel++;
      end

      if (imem_rsp_valid) begin
         r = memQ.pop_front();
         w = memWord(r.addr);
         if (!redir) begin
            if (stale > 0) stale--;
            else if (!mHalted) begin
               occ++;
               if (HALT_EN && w[31:26] == 6'b010001) mHalted = 1'b1;
            end
         end
      end

      if (redir) begin
         occ = 0;
         stale = memQ.size();
         mHalted = 1'b0;
         expPc = rpc;
         expReqPc = rpc;
      end

      if (imem_req_valid && rdy) begin
         d = cycle + lat;
         if (d <= lastDue) d = lastDue + 1;
         lastDue = d;
         r.addr = imem_req_addr;
         r.due = d;
         memQ.push_back(r);
         expReqPc += 4;
         nReq++;
      end

      mRun = 1'b1;
      @(posedge clk);
      #1;
      cycle++;
   endtask

   // Test sequence mirroring the fetch-stage scenarios, followed by a random soak
   initial begin
      int d0;
      int guard;
      bit got;
      checks = 0;
      errors = 0;
      cycle = 0;
      lat = 1;
      haltAddr = 32'hFFFF_FFFC;

      // Reset values
      doReset();
      reset = 1'b0;
      #1;
      checkOutput("rstReqValid", imem_req_valid, 0);
      checkOutput("rstIfValid", if_valid, 0);
      checkOutput("rstIfPc", if_pc, 0);
      checkOutput("rstIfInstr", if_instr, 0);
      checkOutput("rstHalted", halted, 0);
      doReset();

      // Decode stalled: exactly QDEPTH requests, head held at RESET_PC
      for (int i = 0; i < 10; i++) applyStimulus(1, 0, 0, 0);
      checkOutput("holdReqs", nReq, QDEPTH);
      checkOutput("holdPc", if_pc, RESET_PC);
      d0 = nDel;
      for (int i = 0; i < 4; i++) applyStimulus(0, 1, 0, 0);
      checkOutput("holdBurst", nDel - d0, 4);

      // Streaming: one instruction per cycle once filled
      for (int i = 0; i < 10; i++) applyStimulus(1, 1, 0, 0);
      d0 = nDel;
      for (int i = 0; i < 10; i++) applyStimulus(1, 1, 0, 0);
      checkOutput("throughput", nDel - d0, 10);

      // Redirect with two latency-3 responses in flight
      guard = 0;
      while ((memQ.size() > 0 || occ > 0) && guard < 40) begin applyStimulus(0, 1, 0, 0); guard++; end
      checkOutput("drainTimeout", guard < 40, 1);
      lat = 3;
      applyStimulus(1, 1, 0, 0);
      applyStimulus(1, 1, 0, 0);
      applyStimulus(1, 1, 1, 32'h100);
      d0 = nDel;
      guard = 0;
      while (nDel == d0 && guard < 30) begin applyStimulus(1, 1, 0, 0); guard++; end
      checkOutput("redirDelivered", nDel > d0, 1);

      // Memory stalled: address and valid held
      guard = 0;
      while ((memQ.size() > 0 || occ > 0) && guard < 40) begin applyStimulus(0, 1, 0, 0); guard++; end
      for (int i = 0; i < 5; i++) begin
         applyStimulus(0, 1, 0, 0);
         checkOutput("stallValid", imem_req_valid, 1);
         checkOutput("stallAddr", imem_req_addr, expReqPc);
      end

      // Random soak
      for (int i = 0; i < 1500; i++) begin
         lat = $urandom_range(1, 4);
         applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                       $urandom_range(0, 29) == 0, $urandom & 32'h0000_FFFC);
      end

      // Asynchronous reset with three entries queued
      lat = 1;
      guard = 0;
      while (occ < 3 && guard < 30) begin applyStimulus(1, 0, 0, 0); guard++; end
      checkOutput("fillTimeout", occ, 3);
      #2;
      reset = 1'b0;
      #1;
      checkOutput("asyncIfValid", if_valid, 0);
      checkOutput("asyncIfPc", if_pc, 0);
      checkOutput("asyncReqValid", imem_req_valid, 0);
      doReset();
      d0 = nDel;
      guard = 0;
      while (nDel == d0 && guard < 20) begin applyStimulus(1, 1, 0, 0); guard++; end
      checkOutput("restartDelivered", nDel > d0, 1);

`ifdef HALT_DETECT_EN
      // HALT at 0x8 stops fetch; redirect resumes it
      doReset();
      haltAddr = 32'h8;
      for (int i = 0; i < 30; i++) applyStimulus(1, 1, 0, 0);
      checkOutput("haltSet", halted, 1);
      checkOutput("haltDelivered", nDel, 3);
      applyStimulus(1, 1, 1, 32'h20);
      checkOutput("haltClear", halted, 0);
      d0 = nDel;
      got = 1'b0;
      guard = 0;
      while (nDel == d0 && guard < 20) begin applyStimulus(1, 1, 0, 0); guard++; end
      got = (nDel > d0);
      checkOutput("haltResume", got, 1);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
